// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the round-robin FIFO write arbiter: FSM encoding
// and default parameter values.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_NREQ     = 4;
    localparam int unsigned DEF_MAXBEATS = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester set in req, searching
// upward from (last_owner+1) mod NREQ with wrap.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_owner,
    output logic [NREQ-1:0]         pick,
    output logic                    found
);

    localparam int unsigned IW = $clog2(NREQ);

    always_comb begin
        pick  = '0;
        found = 1'b0;
        // k = NREQ wraps back to last_owner itself, so a lone requester is re-granted
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!found && req[IW'((32'(last_owner) + k) % NREQ)]) begin
                pick[IW'((32'(last_owner) + k) % NREQ)] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// Packet-level round-robin arbiter granting one requester at a time the write
// port of a downstream synchronous FIFO, with a beat limit per packet.
module fifo_rr_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned NREQ     = DEF_NREQ,
    parameter int unsigned MAXBEATS = DEF_MAXBEATS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  fifo_full,
    output logic                  fifo_w_en,
    output logic [WIDTH-1:0]      fifo_din,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic                  len_err
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(MAXBEATS + 1);

    state_t           state;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    last_owner;
    logic [IW-1:0]    pick_idx;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [NREQ-1:0]  pick;
    logic             found;
    logic             xfer;
    logic             release_pkt;
    logic [WIDTH-1:0] lane [NREQ];

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req        (req_valid),
        .last_owner (last_owner),
        .pick       (pick),
        .found      (found)
    );

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
        assign lane[gi] = req_data[gi*WIDTH +: WIDTH];
    end

    // One-hot pick to index of the next owner
    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick[i]) pick_idx = IW'(i);
        end
    end

    // Only the owner sees ready; reset suppresses any handshake in its cycle
    always_comb begin
        req_ready = '0;
        if (state == ST_LOCK && !reset && !fifo_full) req_ready[owner] = 1'b1;
    end

    assign xfer        = req_valid[owner] & req_ready[owner];
    assign count_next  = count + CW'(1);
    assign release_pkt = xfer & (req_last[owner] | (count_next == CW'(MAXBEATS)));

    assign fifo_w_en = xfer;
    assign fifo_din  = (state == ST_LOCK) ? lane[owner] : '0;
    assign busy      = (state == ST_LOCK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= '0;
            owner      <= '0;
            last_owner <= IW'(NREQ - 1);
            count      <= '0;
            len_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state <= ST_LOCK;
                        grant <= pick;
                        owner <= pick_idx;
                        count <= '0;
                    end
                end
                ST_LOCK: begin
                    if (xfer) count <= count_next;
                    if (release_pkt) begin
                        state      <= ST_IDLE;
                        grant      <= '0;
                        last_owner <= owner;
                        if (!req_last[owner]) len_err <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fifo_rr_write_arbiter.md
FIFO_RR_WRITE_ARBITER -- requirements
Module: fifo_rr_write_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WIDTH, 8, data width of each requester and of the FIFO write port.
  NREQ, 4, number of requesters (2..8).
  MAXBEATS, 16, maximum beats per packet before forced release.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  clock; all logic on rising edge.
  reset  in  1  synchronous, active-high reset.
  req_valid  in  NREQ  per-requester beat valid.
  req_last  in  NREQ  per-requester last beat of packet.
  req_data  in  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
  req_ready  out  NREQ  per-requester beat accepted.
  fifo_full  in  1  full flag of the downstream synchronous FIFO.
  fifo_w_en  out  1  FIFO write enable.
  fifo_din  out  WIDTH  FIFO write data.
  grant  out  NREQ  one-hot registered owner; all-zero when idle.
  busy  out  1  high while a packet owns the FIFO.
  len_err  out  1  sticky; set on forced release at MAXBEATS.

Function
REQ-003 The FSM SHALL have two states: IDLE and LOCK.
REQ-004 In IDLE with any req_valid high, the block SHALL select the first valid requester, searching from (last_owner+1) mod NREQ upward with wrap. It SHALL load grant, enter LOCK and clear the beat counter at the next edge.
REQ-005 In IDLE, req_ready SHALL be all-zero and fifo_w_en SHALL be 0. This gives one bubble cycle per packet.
REQ-006 In LOCK, req_ready[g] SHALL equal ~fifo_full combinationally for owner g, and all other req_ready bits SHALL be 0.
REQ-007 A beat SHALL transfer when req_valid[g] & req_ready[g]. In that cycle fifo_w_en=1 and fifo_din=req_data of g, giving zero-cycle latency.
REQ-008 When no beat transfers, fifo_w_en SHALL be 0. fifo_din SHALL equal req_data of g in LOCK and 0 in IDLE.
REQ-009 The beat counter SHALL be $clog2(MAXBEATS+1) bits wide and SHALL increment on each transfer. It SHALL NOT wrap, because REQ-011 releases first.
REQ-010 A transfer with req_last[g]=1 SHALL release the packet at the next edge: state to IDLE, grant to 0, last_owner to g.
REQ-011 A transfer that makes the count equal MAXBEATS without req_last SHALL release as in REQ-010 and SHALL set len_err.
REQ-012 A stall (fifo_full=1 in LOCK) SHALL hold state, grant and count indefinitely, with fifo_w_en=0.
REQ-013 Deasserting req_valid[g] mid-packet SHALL NOT release the grant.
REQ-014 busy SHALL equal (state==LOCK). grant SHALL be one-hot in LOCK.
REQ-015 Requests from non-owners SHALL be ignored until IDLE. A requester that is valid alone SHALL be re-granted after its own release, following the rotation order.

Reset
REQ-016 Reset SHALL dominate all other inputs in the cycle it is sampled.
REQ-017 Reset SHALL force: state IDLE, grant 0, busy 0, len_err 0, beat count 0, last_owner NREQ-1 (so requester 0 has priority first).
REQ-018 Reset asserted mid-packet SHALL abort the packet without issuing fifo_w_en. Beats already written SHALL remain in the FIFO, because FIFO reset is owned by the parent.

Structure
REQ-019 Shared package fifo_arb_pkg SHALL hold the state encoding (IDLE=0, LOCK=1) and the default values for WIDTH, NREQ and MAXBEATS.
REQ-020 Round-robin selection SHALL live in a combinational sub-module rr_pick with inputs req[NREQ] and last_owner, and outputs one-hot pick and found.
REQ-021 The FIFO SHALL NOT be instantiated inside this block.

Verification
REQ-022 After reset, req_valid=0001 with a 3-beat packet 0xA1, 0xA2, 0xA3 (last on beat 3) -> grant=0001 one cycle later. fifo_w_en SHALL be high for exactly 3 consecutive cycles with din A1, A2, A3. Then idle, with last_owner=0.
REQ-023 All four requesters valid continuously with 1-beat packets -> grant order 0, 1, 2, 3, 0, with an IDLE cycle between each.
REQ-024 Mid-packet, hold fifo_full=1 for 5 cycles -> req_ready=0 and fifo_w_en=0 for those 5 cycles. No beat is lost or duplicated, and the grant is held.
REQ-025 Requester 2 sends 16 beats with no last, MAXBEATS=16 -> release after beat 16, len_err=1 and sticky. The next valid requester, 3, is granted.
REQ-026 Assert reset in the cycle a beat is presented in LOCK -> no fifo_w_en that cycle. On the next cycle grant=0, busy=0, len_err=0.
REQ-027 Requester 1 drops valid for 3 cycles mid-packet while requester 0 is valid -> grant stays 0010 until req_last from requester 1.
